vproc_mem_model: RTL and testbench
==================================

Name: vproc_mem_model

Overview:
- Parametrised multi-port memory responder with programmable latency.
- Serves vproc_top (MEM_W) and MMU-side masters in simulation and FPGA-emulation builds; replaces ad-hoc latency queues in benches.
- NUM_PORTS request ports share one word-addressed array through a round-robin arbiter and a LATENCY-deep response pipeline.
- Adds explicit grant, a base-address window and per-port response routing.

Parameters:
- NUM_PORTS, 2, number of independent request ports (1..8)
- MEM_W, 32, data width in bits (32, 64 or 128)
- MEM_SZ, 262144, array size in bytes (power of two)
- LATENCY, 1, cycles from grant to rvalid (1..16)
- BASE_ADDR, 32'h0000_0000, byte address mapped to array word 0

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- req_i  in  NUM_PORTS  request valid per port
- gnt_o  out  NUM_PORTS  request accepted this cycle (one-hot or zero)
- addr_i  in  NUM_PORTS*32  byte address per port
- we_i  in  NUM_PORTS  write enable per port
- be_i  in  NUM_PORTS*(MEM_W/8)  byte enables per port
- wdata_i  in  NUM_PORTS*MEM_W  write data per port
- rvalid_o  out  NUM_PORTS  response valid per port
- err_o  out  NUM_PORTS  response error per port
- rdata_o  out  NUM_PORTS*MEM_W  read data per port

Behaviour:
- Reset: gnt_o, rvalid_o, err_o, rdata_o = 0; pipeline valid bits cleared; arbiter pointer = port 0. Array contents not reset.
- Handshake: a request transfers when req_i[p] & gnt_o[p]. Master holds addr/we/be/wdata stable while req_i is high and not granted. gnt_o is combinational from req_i and the pointer.
- Arbitration: at most one grant per cycle, round-robin. Search starts at pointer; after a grant to p, pointer = (p+1) mod NUM_PORTS. With no requests, pointer is unchanged.
- Offset: off = addr - BASE_ADDR (32-bit wrap). Word index = off[$clog2(MEM_SZ)-1:$clog2(MEM_W/8)]. Low bits are ignored (aligned access).
- err: set when off[31:$clog2(MEM_SZ)] != 0 or addr < BASE_ADDR. Erroring writes do not modify the array. Erroring reads return rdata 0.
- Write: the array updates at the grant clock edge for each byte with be=1. A response (rvalid=1, rdata=0) is still returned after LATENCY cycles.
- Read: data is sampled at the grant edge into pipeline stage 1. A read granted the cycle after a write to the same word sees the new data.
- Pipeline: LATENCY stages each hold {valid, port id, err, data}. Stage LATENCY drives rvalid_o/err_o/rdata_o of its port id for exactly one cycle. Other ports show rvalid=0 and rdata=0.
- Throughput: one request per cycle sustained, with no back-pressure on responses. Responses return in grant order.
- Port-id width is max(1, $clog2(NUM_PORTS)).
- Reset mid-operation: in-flight responses are dropped and never delivered. Array writes already granted persist.
- Simultaneous requests on all ports with pointer=k: port k is granted first, then k+1, and so on.
- Static assertions: LATENCY >= 1; MEM_SZ is a power of two; MEM_W % 32 == 0.

Optional Feature:
- Macro VPROC_MEM_STALL_EN.
- Defined: a 16-bit Galois LFSR (poly 0xB400, reset seed 0xACE1) advances every cycle. When lfsr[1:0] == 2'b00, all grants are suppressed that cycle, giving a pseudo-random 25% stall. The pointer does not advance on a stalled cycle.
- Not defined: no LFSR, and grants follow the arbitration rules only.

Decomposition:
- Package vproc_mem_model_pkg holds:
  - typedef mem_req_t {addr, we, be, wdata}
  - typedef mem_rsp_t {rvalid, err, rdata}
  - localparam LFSR_SEED
  - localparam LFSR_POLY
  - function port_id_w(n)
- Sub-module vproc_mem_rr_arb: NUM_PORTS-wide round-robin arbiter with req, gnt, stall input and pointer register.

Test Plan:
- LATENCY=3, port0 write 0xDEADBEEF be=4'hF at 0x100, then read 0x100 -> gnt same cycle; read rvalid 3 cycles after its grant, rdata=0xDEADBEEF, err=0.
- Partial write be=4'b0101 data 0x11223344 over word 0xFFFFFFFF -> read returns 0xFF22FF44.
- Ports 0 and 1 request continuously for 6 cycles, LATENCY=1 -> grants alternate 0,1,0,1,0,1; each rvalid is routed only to its own port.
- BASE_ADDR=0x2000: read 0x1FFC -> err=1, rdata=0; read MEM_SZ+0x2000 -> err=1; write to an error address leaves the array unchanged.
- Assert rst_ni low with 2 responses in flight (LATENCY=4) -> no rvalid after release; pointer back to port 0.
- VPROC_MEM_STALL_EN defined, port0 requests for 1000 cycles -> grant count in 700..800; every granted request gets exactly one response in order.

Source files
------------

// File: rtl/vproc_mem_model_pkg.sv
// Shared types and constants for the vproc multi-port memory responder.
package vproc_mem_model_pkg;

  localparam int unsigned MEM_W_MAX  = 128;
  localparam int unsigned MEM_BE_MAX = MEM_W_MAX / 8;

  // Stall LFSR: 16-bit Galois, right-shifting, taps 0xB400
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_POLY = 16'hB400;

  // Request payload, sized for the widest supported data bus
  typedef struct packed {
    logic [31:0]             addr;
    logic                    we;
    logic [MEM_BE_MAX-1:0]   be;
    logic [MEM_W_MAX-1:0]    wdata;
  } mem_req_t;

  // Response payload, sized for the widest supported data bus
  typedef struct packed {
    logic                    rvalid;
    logic                    err;
    logic [MEM_W_MAX-1:0]    rdata;
  } mem_rsp_t;

  // Port-id width; a single port still carries a 1-bit id
  function automatic int unsigned port_id_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vproc_mem_rr_arb.sv
// Round-robin arbiter: one grant per cycle, search starts at the pointer,
// pointer moves past the winner. stall_i suppresses grants and freezes the pointer.
module vproc_mem_rr_arb
  import vproc_mem_model_pkg::*;
#(
  parameter int unsigned NUM_PORTS = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [NUM_PORTS-1:0] req_i,
  input  logic                 stall_i,
  output logic [NUM_PORTS-1:0] gnt_c
);

  localparam int unsigned ID_W = port_id_w(NUM_PORTS);

  logic [ID_W-1:0] ptr_q;
  logic [ID_W-1:0] ptr_d;

  // Pointer register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  // Search from the pointer for the first requester; grant it and advance past it
  always_comb begin
    logic            found;
    logic [ID_W-1:0] cand;
    gnt_c = '0;
    ptr_d = ptr_q;
    found = 1'b0;
    cand  = '0;
    if (!stall_i) begin
      for (int unsigned i = 0; i < NUM_PORTS; i++) begin
        cand = ID_W'((32'(ptr_q) + i) % NUM_PORTS);
        if (!found && req_i[cand]) begin
          found       = 1'b1;
          gnt_c[cand] = 1'b1;
          ptr_d       = ID_W'((32'(cand) + 32'd1) % NUM_PORTS);
        end
      end
    end
  end

endmodule

// File: rtl/vproc_mem_model.sv
// Multi-port memory responder: round-robin arbitration into one word array,
// LATENCY-deep response pipeline routed back to the requesting port.
// Optional macro VPROC_MEM_STALL_EN adds an LFSR-driven ~25% grant stall.
module vproc_mem_model
  import vproc_mem_model_pkg::*;
#(
  parameter int unsigned NUM_PORTS = 2,
  parameter int unsigned MEM_W     = 32,
  parameter int unsigned MEM_SZ    = 262144,
  parameter int unsigned LATENCY   = 1,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic [NUM_PORTS-1:0]         req_i,
  output logic [NUM_PORTS-1:0]         gnt_o,
  input  logic [NUM_PORTS*32-1:0]      addr_i,
  input  logic [NUM_PORTS-1:0]         we_i,
  input  logic [NUM_PORTS*(MEM_W/8)-1:0] be_i,
  input  logic [NUM_PORTS*MEM_W-1:0]   wdata_i,
  output logic [NUM_PORTS-1:0]         rvalid_o,
  output logic [NUM_PORTS-1:0]         err_o,
  output logic [NUM_PORTS*MEM_W-1:0]   rdata_o
);

  localparam int unsigned BE_W    = MEM_W / 8;
  localparam int unsigned ID_W    = port_id_w(NUM_PORTS);
  localparam int unsigned SZ_W    = $clog2(MEM_SZ);
  localparam int unsigned OFF_LSB = $clog2(BE_W);
  localparam int unsigned IDX_W   = SZ_W - OFF_LSB;
  localparam int unsigned DEPTH   = MEM_SZ / BE_W;

  // Elaboration-time parameter checks
  if (LATENCY < 1) begin : g_chk_lat
    $error("vproc_mem_model: LATENCY must be >= 1");
  end
  if ((MEM_SZ & (MEM_SZ - 1)) != 0) begin : g_chk_sz
    $error("vproc_mem_model: MEM_SZ must be a power of two");
  end
  if ((MEM_W % 32) != 0 || MEM_W > MEM_W_MAX) begin : g_chk_w
    $error("vproc_mem_model: MEM_W must be 32, 64 or 128");
  end

  logic                 stall_c;
  mem_req_t             sel_req;
  logic [ID_W-1:0]      sel_id;
  logic [31:0]          off;
  logic                 acc_err;
  logic [IDX_W-1:0]     idx;
  logic [MEM_W-1:0]     rd_word;
  mem_rsp_t             in_rsp;
  logic [MEM_W-1:0]     mem [DEPTH];

  logic                 lst_vld;
  logic [ID_W-1:0]      lst_id;
  logic                 lst_err;
  logic [MEM_W-1:0]     lst_data;
  logic                 unused_c;

`ifdef VPROC_MEM_STALL_EN
  logic [15:0] lfsr_q;

  // Free-running Galois LFSR; low two bits zero means stall this cycle
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= lfsr_q[0] ? ((lfsr_q >> 1) ^ LFSR_POLY) : (lfsr_q >> 1);
    end
  end

  assign stall_c = (lfsr_q[1:0] == 2'b00);
`else
  assign stall_c = 1'b0;
`endif

  vproc_mem_rr_arb #(
    .NUM_PORTS (NUM_PORTS)
  ) u_arb (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .req_i   (req_i),
    .stall_i (stall_c),
    .gnt_c   (gnt_o)
  );

  // Select the granted port's request payload (zero when nothing is granted)
  always_comb begin
    sel_req = '0;
    sel_id  = '0;
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      if (gnt_o[p]) begin
        sel_req.addr  = addr_i[p*32 +: 32];
        sel_req.we    = we_i[p];
        sel_req.be    = MEM_BE_MAX'(be_i[p*BE_W +: BE_W]);
        sel_req.wdata = MEM_W_MAX'(wdata_i[p*MEM_W +: MEM_W]);
        sel_id        = ID_W'(p);
      end
    end
  end

  // Window decode: offset from base, error when below base or past the array
  always_comb begin
    off     = sel_req.addr - BASE_ADDR;
    acc_err = (sel_req.addr < BASE_ADDR) || ((off >> SZ_W) != 32'd0);
    idx     = off[SZ_W-1:OFF_LSB];
    rd_word = mem[idx];
  end

  // Stage-1 entry: reads return array data, writes and errors return zero
  always_comb begin
    in_rsp        = '0;
    in_rsp.rvalid = |gnt_o;
    in_rsp.err    = (|gnt_o) & acc_err;
    if ((|gnt_o) && !sel_req.we && !acc_err) begin
      in_rsp.rdata = MEM_W_MAX'(rd_word);
    end
  end

  // Byte-enabled array write at the grant edge; contents are never reset
  always_ff @(posedge clk_i) begin
    if ((|gnt_o) && sel_req.we && !acc_err) begin
      for (int unsigned b = 0; b < BE_W; b++) begin
        if (sel_req.be[b]) begin
          mem[idx][b*8 +: 8] <= sel_req.wdata[b*8 +: 8];
        end
      end
    end
  end

  if (LATENCY > 1) begin : g_pipe
    localparam int unsigned NSTG = LATENCY - 1;
    logic [NSTG-1:0]  vld_q;
    logic [NSTG-1:0]  err_q;
    logic [ID_W-1:0]  id_q   [NSTG];
    logic [MEM_W-1:0] data_q [NSTG];

    // Stages 1..LATENCY-1; the output registers act as the final stage
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        vld_q <= '0;
        err_q <= '0;
        for (int unsigned s = 0; s < NSTG; s++) begin
          id_q[s]   <= '0;
          data_q[s] <= '0;
        end
      end else begin
        vld_q[0]  <= in_rsp.rvalid;
        err_q[0]  <= in_rsp.err;
        id_q[0]   <= sel_id;
        data_q[0] <= in_rsp.rdata[MEM_W-1:0];
        for (int unsigned s = 1; s < NSTG; s++) begin
          vld_q[s]  <= vld_q[s-1];
          err_q[s]  <= err_q[s-1];
          id_q[s]   <= id_q[s-1];
          data_q[s] <= data_q[s-1];
        end
      end
    end

    assign lst_vld  = vld_q[NSTG-1];
    assign lst_err  = err_q[NSTG-1];
    assign lst_id   = id_q[NSTG-1];
    assign lst_data = data_q[NSTG-1];
  end else begin : g_nopipe
    assign lst_vld  = in_rsp.rvalid;
    assign lst_err  = in_rsp.err;
    assign lst_id   = sel_id;
    assign lst_data = in_rsp.rdata[MEM_W-1:0];
  end

  // Final stage: route the response to its port for one cycle, others stay zero
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rvalid_o <= '0;
      err_o    <= '0;
      rdata_o  <= '0;
    end else begin
      for (int unsigned p = 0; p < NUM_PORTS; p++) begin
        rvalid_o[p]              <= lst_vld && (lst_id == ID_W'(p));
        err_o[p]                 <= lst_vld && (lst_id == ID_W'(p)) && lst_err;
        rdata_o[p*MEM_W +: MEM_W] <= (lst_vld && (lst_id == ID_W'(p))) ? lst_data : '0;
      end
    end
  end

  // Payload bits outside the configured width and sub-word address bits
  assign unused_c = ^{sel_req, in_rsp, off};

endmodule

// File: tb/tb_vproc_mem_model.sv
// Self-checking bench for vproc_mem_model: directed scenarios plus random
// multi-port traffic against a transaction-level reference model.
module tb_vproc_mem_model;

  localparam int unsigned NP   = 3;
  localparam int unsigned DW   = 32;
  localparam int unsigned BW   = DW / 8;
  localparam int unsigned MSZ  = 4096;
  localparam int unsigned LAT  = 3;
  localparam logic [31:0] BASE = 32'h0000_2000;
`ifdef VPROC_MEM_STALL_EN
  localparam bit STALL_EN = 1'b1;
`else
  localparam bit STALL_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_ni;
  logic [NP-1:0]     req, gnt, we, rvalid, err;
  logic [NP*32-1:0]  addr;
  logic [NP*BW-1:0]  be;
  logic [NP*DW-1:0]  wdata, rdata;

  always #5 clk = ~clk;

  vproc_mem_model #(
    .NUM_PORTS (NP),
    .MEM_W     (DW),
    .MEM_SZ    (MSZ),
    .LATENCY   (LAT),
    .BASE_ADDR (BASE)
  ) dut (
    .clk_i    (clk),
    .rst_ni   (rst_ni),
    .req_i    (req),
    .gnt_o    (gnt),
    .addr_i   (addr),
    .we_i     (we),
    .be_i     (be),
    .wdata_i  (wdata),
    .rvalid_o (rvalid),
    .err_o    (err),
    .rdata_o  (rdata)
  );

  typedef struct {
    int          due;
    int          port;
    bit          err;
    logic [DW-1:0] data;
  } rsp_t;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  int            cyc = 0;
  int            ptr = 0;
  logic [15:0]   lfsr = 16'hACE1;
  rsp_t          q[$];
  logic [DW-1:0] mem_m [int unsigned];
  bit            pend [NP];
  logic [31:0]   pa   [NP];
  bit            pw   [NP];
  logic [BW-1:0] pbe  [NP];
  logic [DW-1:0] pwd  [NP];
  int            last_gp;
  int            grants   = 0;
  int            rv_total = 0;
  int            gnt_cyc [NP];
  int            rv_cyc  [NP];
  logic [DW-1:0] last_rdata [NP];
  bit            last_err   [NP];

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock: drive held requests, compare at negedge, commit model, advance
  task automatic step();
    logic [NP-1:0]    eg, erv, eer;
    logic [NP*DW-1:0] erd;
    int               gp;
    bit               stall, e;
    logic [31:0]      off;
    logic [DW-1:0]    d, w;
    rsp_t             r;
    for (int p = 0; p < NP; p++) begin
      req[p]              = rst_ni & pend[p];
      addr[p*32 +: 32]    = pa[p];
      we[p]               = pw[p];
      be[p*BW +: BW]      = pbe[p];
      wdata[p*DW +: DW]   = pwd[p];
    end
    @(negedge clk);
    eg = '0; erv = '0; eer = '0; erd = '0; gp = -1;
    stall = STALL_EN && (lfsr[1:0] == 2'b00);
    if (rst_ni && !stall) begin
      for (int i = 0; i < NP; i++) begin
        if (gp < 0 && pend[(ptr + i) % NP]) gp = (ptr + i) % NP;
      end
    end
    if (gp >= 0) eg[gp] = 1'b1;
    if (q.size() > 0 && q[0].due == cyc) begin
      r = q.pop_front();
      erv[r.port] = 1'b1;
      eer[r.port] = r.err;
      erd[r.port*DW +: DW] = r.data;
    end
    check_eq("gnt", gnt, eg);
    check_eq("rvalid", rvalid, erv);
    check_eq("err", err, eer);
    check_eq("rdata", rdata, erd);
    for (int p = 0; p < NP; p++) begin
      if (rvalid[p] === 1'b1) begin
        rv_cyc[p]     = cyc;
        last_rdata[p] = rdata[p*DW +: DW];
        last_err[p]   = err[p];
        rv_total++;
      end
    end
    last_gp = gp;
    if (gp >= 0) begin
      off = pa[gp] - BASE;
      e   = (pa[gp] < BASE) || (off >= MSZ);
      d   = '0;
      if (!e) begin
        w = mem_m.exists(off >> 2) ? mem_m[off >> 2] : '0;
        if (pw[gp]) begin
          for (int b = 0; b < BW; b++) if (pbe[gp][b]) w[b*8 +: 8] = pwd[gp][b*8 +: 8];
          mem_m[off >> 2] = w;
        end else begin
          d = w;
        end
      end
      q.push_back('{due: cyc + LAT, port: gp, err: e, data: d});
      pend[gp]    = 1'b0;
      ptr         = (gp + 1) % NP;
      gnt_cyc[gp] = cyc;
      grants++;
    end
    if (rst_ni) lfsr = lfsr[0] ? ((lfsr >> 1) ^ 16'hB400) : (lfsr >> 1);
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic apply_reset(input int n);
    rst_ni = 1'b0;
    q.delete();
    ptr  = 0;
    lfsr = 16'hACE1;
    repeat (n) step();
    rst_ni = 1'b1;
  endtask

  task automatic issue(input int p, input logic [31:0] a, input bit w, input logic [BW-1:0] b,
                       input logic [DW-1:0] wd, output int n);
    pend[p] = 1'b1; pa[p] = a; pw[p] = w; pbe[p] = b; pwd[p] = wd;
    n = 0;
    while (pend[p] && n < 50) begin
      step();
      n++;
    end
    check_eq("issue_timeout", pend[p], 1'b0);
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() > 0 && n < 50) begin
      step();
      n++;
    end
    step();
    check_eq("drain_timeout", q.size(), 0);
  endtask

  initial begin
    int n, k, snap;
    int seq[$];
    rst_ni = 1'b0;
    for (int p = 0; p < NP; p++) begin
      pend[p] = 1'b0; pa[p] = BASE; pw[p] = 1'b0; pbe[p] = '0; pwd[p] = '0;
      last_rdata[p] = '0; last_err[p] = 1'b0; gnt_cyc[p] = 0; rv_cyc[p] = 0;
    end
    @(posedge clk);
    #1;
    apply_reset(3);

    // Initialise the word pool used by all later traffic
    for (int i = 0; i < 32; i++) issue(0, BASE + 32'h100 + 32'(i * 4), 1'b1, 4'hF, DW'($urandom), n);
    issue(0, BASE + 32'(MSZ) - 32'd4, 1'b1, 4'hF, 32'hCAFE_F00D, n);
    drain();

    // Full write then read back, check latency
    issue(0, BASE + 32'h100, 1'b1, 4'hF, 32'hDEAD_BEEF, n);
`ifndef VPROC_MEM_STALL_EN
    check_eq("wr_gnt_same_cycle", n, 1);
`endif
    issue(0, BASE + 32'h100, 1'b0, 4'h0, 32'h0, n);
    drain();
    check_eq("rd_data", last_rdata[0], 32'hDEAD_BEEF);
    check_eq("rd_err", last_err[0], 1'b0);
    check_eq("rd_latency", rv_cyc[0] - gnt_cyc[0], LAT);

    // Partial write
    issue(0, BASE + 32'h104, 1'b1, 4'hF, 32'hFFFF_FFFF, n);
    issue(0, BASE + 32'h104, 1'b1, 4'b0101, 32'h1122_3344, n);
    issue(0, BASE + 32'h104, 1'b0, 4'h0, 32'h0, n);
    drain();
    check_eq("partial_wr", last_rdata[0], 32'hFF22_FF44);

    // Write on one port, read of the same word on another granted right after
    pend[1] = 1'b1; pa[1] = BASE + 32'h108; pw[1] = 1'b1; pbe[1] = 4'hF; pwd[1] = 32'h5A5A_1234;
    pend[2] = 1'b1; pa[2] = BASE + 32'h108; pw[2] = 1'b0; pbe[2] = 4'h0; pwd[2] = 32'h0;
    n = 0;
    while ((pend[1] || pend[2]) && n < 50) begin
      step();
      n++;
    end
    drain();
    check_eq("wr_then_rd", last_rdata[2], 32'h5A5A_1234);

    // Window errors and top-of-window boundary
    issue(0, BASE - 32'd4, 1'b0, 4'h0, 32'h0, n);
    drain();
    check_eq("err_below_base", last_err[0], 1'b1);
    check_eq("err_below_rdata", last_rdata[0], 32'h0);
    issue(0, BASE + 32'(MSZ), 1'b0, 4'h0, 32'h0, n);
    drain();
    check_eq("err_above_win", last_err[0], 1'b1);
    issue(0, BASE + 32'(MSZ) + 32'h100, 1'b1, 4'hF, 32'h0BAD_F00D, n);
    issue(0, BASE + 32'h100, 1'b0, 4'h0, 32'h0, n);
    drain();
    check_eq("err_wr_no_alias", last_rdata[0], 32'hDEAD_BEEF);
    issue(0, BASE + 32'(MSZ) - 32'd4, 1'b0, 4'h0, 32'h0, n);
    drain();
    check_eq("top_word", last_rdata[0], 32'hCAFE_F00D);
    check_eq("top_word_err", last_err[0], 1'b0);

    // Reset with responses in flight: they must never appear
    pend[0] = 1'b1; pa[0] = BASE + 32'h100; pw[0] = 1'b0;
    pend[1] = 1'b1; pa[1] = BASE + 32'h104; pw[1] = 1'b0;
    step();
    step();
    pend[0] = 1'b0; pend[1] = 1'b0;
    snap = rv_total;
    apply_reset(2);
    repeat (8) step();
    check_eq("rst_drop", rv_total - snap, 0);

    // Two ports requesting continuously after reset: 0,1,0,1,...
    n = 0;
    while (seq.size() < 6 && n < 40) begin
      pend[0] = 1'b1; pa[0] = BASE + 32'h100; pw[0] = 1'b0;
      pend[1] = 1'b1; pa[1] = BASE + 32'h104; pw[1] = 1'b0;
      step();
      if (last_gp >= 0) seq.push_back(last_gp);
      n++;
    end
    pend[0] = 1'b0; pend[1] = 1'b0;
    for (int i = 0; i < 6; i++) check_eq("alt_gnt", (seq.size() > i) ? seq[i] : -1, i % 2);
    drain();

`ifdef VPROC_MEM_STALL_EN
    // Single requester under stall: roughly 75% of cycles granted
    snap = grants;
    repeat (1000) begin
      pend[0] = 1'b1; pa[0] = BASE + 32'h100 + 32'($urandom_range(0, 31) * 4); pw[0] = 1'b0;
      step();
    end
    pend[0] = 1'b0;
    drain();
    check_eq("stall_grant_range", ((grants - snap) >= 700) && ((grants - snap) <= 800), 1'b1);
`endif

    // Random multi-port traffic with one mid-run reset
    for (int c = 0; c < 2500; c++) begin
      for (int p = 0; p < NP; p++) begin
        if (!pend[p] && $urandom_range(0, 9) < 6) begin
          k = $urandom_range(0, 19);
          if (k == 0)      pa[p] = BASE - 32'($urandom_range(1, 4) * 4);
          else if (k == 1) pa[p] = BASE + 32'(MSZ) + 32'($urandom_range(0, 3) * 4);
          else             pa[p] = BASE + 32'h100 + 32'($urandom_range(0, 31) * 4) + 32'($urandom_range(0, 3));
          pw[p]   = 1'($urandom_range(0, 1));
          pbe[p]  = BW'($urandom);
          pwd[p]  = DW'($urandom);
          pend[p] = 1'b1;
        end
      end
      if (c == 1200) apply_reset(2);
      step();
    end
    for (int p = 0; p < NP; p++) pend[p] = 1'b0;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
